// File: rtl/fpu_pkg.sv
// Shared types and constants for the fpu adder wrapper: status codes, operand
// format widths and the operand sequencer state encoding.
package fpu_pkg;

  localparam int unsigned EXP_W           = 6;
  localparam int unsigned MANT_W          = 25;
  localparam int unsigned FPU_MAX_LATENCY = 31;

  typedef enum logic [3:0] {
    EXACT     = 4'b0001,
    INEXACT   = 4'b0010,
    OVERFLOW  = 4'b0100,
    UNDERFLOW = 4'b1000
  } status_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    CAPTURE = 2'd2,
    OUTPUT  = 2'd3
  } seq_state_t;

  // Event counters stick at all-ones rather than wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic en);
    return (en && (v != 8'hFF)) ? v + 8'd1 : v;
  endfunction

endpackage

// File: rtl/fpu_operand_fifo.sv
// Synchronous show-ahead FIFO for operand pairs; pointers carry an extra wrap
// bit so full and empty are distinguished without a separate count.
module fpu_operand_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 68
) (
  input  logic             clock100KHz,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_ff @(posedge clock100KHz) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clock100KHz) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/fpu_operand_sequencer.sv
// Feeds buffered operand pairs to the free-running fpu adder, holds each for a
// fixed frame, then returns the captured result and status with its tag.
module fpu_operand_sequencer
  import fpu_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned FRAME_CYCLES = 64,
  parameter int unsigned TAG_W        = 4
) (
  input  logic             clock100KHz,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      op_A_out,
  output logic [31:0]      op_B_out,
  input  logic [31:0]      fpu_data_in,
  input  logic [3:0]       fpu_status_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [3:0]       res_status,
  output logic [TAG_W-1:0] res_tag,
  output logic [7:0]       ovf_cnt,
  output logic [7:0]       unf_cnt,
  output logic             busy
);

  localparam int unsigned FW = 64 + TAG_W;
  localparam int unsigned CW = $clog2(FRAME_CYCLES);

  seq_state_t       state;
  logic [CW-1:0]    frame_cnt;
  logic [TAG_W-1:0] tag_q;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic [FW-1:0]    head;

  assign in_ready = !fifo_full;
  assign pop      = (state == IDLE) && !fifo_empty;
  assign busy     = (state != IDLE) || !fifo_empty;

  fpu_operand_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(FW)
  ) u_fifo (
    .clock100KHz(clock100KHz),
    .reset      (reset),
    .push       (in_valid),
    .push_data  ({in_a, in_b, in_tag}),
    .pop        (pop),
    .pop_data   (head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  always_ff @(posedge clock100KHz) begin
    if (reset) begin
      state      <= IDLE;
      frame_cnt  <= '0;
      tag_q      <= '0;
      op_A_out   <= '0;
      op_B_out   <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_status <= '0;
      res_tag    <= '0;
      ovf_cnt    <= '0;
      unf_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            op_A_out  <= head[FW-1 -: 32];
            op_B_out  <= head[TAG_W +: 32];
            tag_q     <= head[TAG_W-1:0];
            frame_cnt <= CW'(FRAME_CYCLES - 1);
            state     <= HOLD;
          end
        end
        // Frame spans FRAME_CYCLES edges: loaded with N-1, leaves on the edge seeing 0.
        HOLD: begin
          if (frame_cnt == '0) begin
            state <= CAPTURE;
          end else begin
            frame_cnt <= frame_cnt - CW'(1);
          end
        end
        CAPTURE: begin
          res_data   <= fpu_data_in;
          res_status <= fpu_status_in;
          res_tag    <= tag_q;
          res_valid  <= 1'b1;
          ovf_cnt    <= sat_inc(ovf_cnt, fpu_status_in[2]);
          unf_cnt    <= sat_inc(unf_cnt, fpu_status_in[3]);
          state      <= OUTPUT;
        end
        OUTPUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
